// File: rtl/vred_pkg.sv
// Shared definitions for the vector reduction sequencer.
//   - state_t      : sequencer FSM states
//   - OPSEL_*      : operation encodings (2'b0x sum, 2'b10 signed min, 2'b11 signed max)
//   - lane_mask()  : mask covering lane 0 for a given sew, up to 64 bits
//   - identity()   : per-lane identity word for (opSel, sew, width)
package vred_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FIRST     = 4'd1,
    ACC       = 4'd2,
    ACC_WAIT  = 4'd3,
    FOLD      = 4'd4,
    FOLD_WAIT = 4'd5,
    INIT      = 4'd6,
    INIT_WAIT = 4'd7,
    DONE      = 4'd8
  } state_t;

  localparam logic [1:0] OPSEL_SUM = 2'b00;
  localparam logic [1:0] OPSEL_MIN = 2'b10;
  localparam logic [1:0] OPSEL_MAX = 2'b11;

  // Lane 0 mask; for sew=3 the shift distance is 64, giving all ones.
  function automatic logic [63:0] lane_mask(input logic [1:0] sew);
    return ~(64'hFFFF_FFFF_FFFF_FFFF << (7'd8 << sew));
  endfunction

  // Identity element replicated into every lane of a w-bit word:
  // sum -> 0, min -> 0x7F..F, max -> 0x80..0. Bits at or above w are 0.
  function automatic logic [63:0] identity(input logic [1:0] op, input logic [1:0] sew,
                                           input int w);
    logic [63:0] v;
    int          lw;
    v  = 64'd0;
    lw = int'(32'd8 << sew);
    for (int i = 0; i < 64; i++) begin
      if (i >= w) begin
        v[i] = 1'b0;
      end else if ((i % lw) == (lw - 1)) begin
        v[i] = (op == OPSEL_MAX);
      end else begin
        v[i] = (op == OPSEL_MIN);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/vred_tail_pad.sv
// Tail-lane padding for vs2 words.
// On the last word, lanes whose element index is >= the remainder of vl are
// replaced with the identity of the current operation so they cannot affect
// the reduction. A remainder of 0 means the last word is full.
// Ports:
//   word    in  W         raw vs2 word, lanes packed LSB-first
//   is_last in  1         word is the final word of the vector
//   rem     in  VL_WIDTH  number of valid lanes in the last word (0 = all)
//   sew     in  SEW_WIDTH element width encoding
//   opSel   in  OPSEL_WIDTH operation
//   padded  out W         word with tail lanes replaced
module vred_tail_pad
  import vred_pkg::*;
#(
  parameter int W           = 32,
  parameter int VL_WIDTH    = 16,
  parameter int SEW_WIDTH   = 2,
  parameter int OPSEL_WIDTH = 2
) (
  input  logic [W-1:0]           word,
  input  logic                   is_last,
  input  logic [VL_WIDTH-1:0]    rem,
  input  logic [SEW_WIDTH-1:0]   sew,
  input  logic [OPSEL_WIDTH-1:0] opSel,
  output logic [W-1:0]           padded
);

  logic [W-1:0]        ident;
  logic [VL_WIDTH-1:0] lane_idx;

  assign ident = W'(identity(opSel, sew, W));

  // Per-bit lane selection between the raw word and the identity.
  always_comb begin
    padded   = word;
    lane_idx = '0;
    for (int i = 0; i < W; i++) begin
      lane_idx = VL_WIDTH'(i >> (3 + int'(sew)));
      if (is_last && (rem != '0) && (lane_idx >= rem)) begin
        padded[i] = ident[i];
      end else begin
        padded[i] = word[i];
      end
    end
  end

endmodule

// File: rtl/vred_sequencer.sv
// Reduction sequencer driving an external 1-cycle registered pairwise
// reduction unit to compute vredsum / vredmin / vredmax.
// Flow: accumulate vs2 words element-wise, fold the accumulator in halves
// down to lane 0, then combine with the vs1[0] scalar.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, vl, sew, opSel, scalar_in   command, sampled in IDLE
//   in_data/in_valid/in_ready          vs2 word stream
//   red_vec0/red_en/red_sew/red_opSel  to reduction unit ({B, A})
//   red_out               from reduction unit (low W bits used)
//   busy                  not IDLE
//   res_valid/res_data    one-cycle result pulse, lane 0 zero-extended
module vred_sequencer
  import vred_pkg::*;
#(
  parameter int REQ_DATA_WIDTH  = 32,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int OPSEL_WIDTH     = 2,
  parameter int SEW_WIDTH       = 2,
  parameter int VL_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [VL_WIDTH-1:0]         vl,
  input  logic [SEW_WIDTH-1:0]        sew,
  input  logic [OPSEL_WIDTH-1:0]      opSel,
  input  logic [REQ_DATA_WIDTH-1:0]   scalar_in,
  input  logic [REQ_DATA_WIDTH-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [2*REQ_DATA_WIDTH-1:0] red_vec0,
  output logic                        red_en,
  output logic [SEW_WIDTH-1:0]        red_sew,
  output logic [OPSEL_WIDTH-1:0]      red_opSel,
  input  logic [RESP_DATA_WIDTH-1:0]  red_out,
  output logic                        busy,
  output logic                        res_valid,
  output logic [REQ_DATA_WIDTH-1:0]   res_data
);

  localparam int W        = REQ_DATA_WIDTH;
  localparam int MAX_LOG2 = $clog2(W / 8);

  state_t                 state;
  state_t                 state_next;
  logic [W-1:0]           acc;
  logic [W-1:0]           scalar;
  logic [W-1:0]           res;
  logic [VL_WIDTH-1:0]    words_left;
  logic [VL_WIDTH-1:0]    pad_rem;
  logic [3:0]             folds_left;
  logic [SEW_WIDTH-1:0]   sew_l;
  logic [OPSEL_WIDTH-1:0] op_l;

  logic                   beat;
  logic [W-1:0]           padded;
  logic [W-1:0]           lmask;
  logic [7:0]             fold_shift;
  logic [3:0]             lane_log2;
  logic [VL_WIDTH:0]      lanes_m1;
  logic [VL_WIDTH-1:0]    words_start;
  logic [VL_WIDTH-1:0]    rem_start;
  logic                   unused_out_hi;

  assign unused_out_hi = ^red_out[RESP_DATA_WIDTH-1:W];

  assign beat = in_valid & in_ready;
  assign lmask = W'(lane_mask(sew_l));

  // Word count and tail remainder derived from the incoming command.
  assign lane_log2   = 4'(MAX_LOG2) - 4'(sew);
  assign lanes_m1    = ~({(VL_WIDTH + 1){1'b1}} << lane_log2);
  assign words_start = VL_WIDTH'(({1'b0, vl} + lanes_m1) >> lane_log2);
  assign rem_start   = vl & lanes_m1[VL_WIDTH-1:0];

  // Half-width of the still-live part of acc for the current fold:
  // (lane bits) << (remaining folds - 1).
  assign fold_shift = (8'd8 << sew_l) << (folds_left - 4'd1);

  vred_tail_pad #(
    .W          (W),
    .VL_WIDTH   (VL_WIDTH),
    .SEW_WIDTH  (SEW_WIDTH),
    .OPSEL_WIDTH(OPSEL_WIDTH)
  ) u_pad (
    .word   (in_data),
    .is_last(words_left == VL_WIDTH'(1)),
    .rem    (pad_rem),
    .sew    (sew_l),
    .opSel  (op_l),
    .padded (padded)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and unit-issue decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    red_en     = 1'b0;
    red_vec0   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (vl != '0) ? FIRST : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      FIRST: begin
        in_ready = 1'b1;
        if (beat && (words_left == VL_WIDTH'(1))) begin
          state_next = (folds_left != 4'd0) ? FOLD : INIT;
        end else if (beat) begin
          state_next = ACC;
        end else begin
          state_next = FIRST;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (beat) begin
          red_en     = 1'b1;
          red_vec0   = {padded, acc};
          state_next = ACC_WAIT;
        end else begin
          state_next = ACC;
        end
      end
      ACC_WAIT: begin
        if (words_left != '0) begin
          state_next = ACC;
        end else begin
          state_next = (folds_left != 4'd0) ? FOLD : INIT;
        end
      end
      FOLD: begin
        red_en     = 1'b1;
        red_vec0   = {acc >> fold_shift, acc};
        state_next = FOLD_WAIT;
      end
      FOLD_WAIT: begin
        if (folds_left > 4'd1) begin
          state_next = FOLD;
        end else begin
          state_next = INIT;
        end
      end
      INIT: begin
        red_en     = 1'b1;
        red_vec0   = {scalar & lmask, acc & lmask};
        state_next = INIT_WAIT;
      end
      INIT_WAIT: state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath: command latch, accumulator, counters and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      scalar     <= '0;
      res        <= '0;
      words_left <= '0;
      pad_rem    <= '0;
      folds_left <= 4'd0;
      sew_l      <= '0;
      op_l       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sew_l      <= sew;
            op_l       <= opSel;
            scalar     <= scalar_in;
            words_left <= words_start;
            pad_rem    <= rem_start;
            folds_left <= 4'(MAX_LOG2) - 4'(sew);
            acc        <= '0;
            // vl==0 bypasses the unit: the result is just the scalar.
            if (vl == '0) begin
              res <= scalar_in & W'(lane_mask(sew));
            end
          end
        end
        FIRST: begin
          if (beat) begin
            acc        <= padded;
            words_left <= words_left - VL_WIDTH'(1);
          end
        end
        ACC: begin
          if (beat) begin
            words_left <= words_left - VL_WIDTH'(1);
          end
        end
        ACC_WAIT: acc <= red_out[W-1:0];
        FOLD_WAIT: begin
          acc        <= red_out[W-1:0];
          folds_left <= folds_left - 4'd1;
        end
        INIT_WAIT: res <= red_out[W-1:0] & lmask;
        default: ;
      endcase
    end
  end

  assign red_sew   = sew_l;
  assign red_opSel = op_l;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = res;

endmodule

// File: tb/tb_vred_sequencer.sv
// Self-checking bench for vred_sequencer (W=32) with a behavioural model of
// the 1-cycle pairwise reduction unit and a scoreboard of expected results.
module tb_vred_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   vl;
  logic [1:0]    sew;
  logic [1:0]    opSel;
  logic [31:0]   scalar_in;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   red_vec0;
  logic          red_en;
  logic [1:0]    red_sew;
  logic [1:0]    red_opSel;
  logic [63:0]   red_out;
  logic          busy;
  logic          res_valid;
  logic [31:0]   res_data;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_beat_cyc = 0;
  logic [31:0] wbuf[0:31];

  vred_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vl       (vl),
    .sew      (sew),
    .opSel    (opSel),
    .scalar_in(scalar_in),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .red_vec0 (red_vec0),
    .red_en   (red_en),
    .red_sew  (red_sew),
    .red_opSel(red_opSel),
    .red_out  (red_out),
    .busy     (busy),
    .res_valid(res_valid),
    .res_data (res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sext(input longint x, input int lw);
    if (((x >> (lw - 1)) & 64'd1) != 64'd0) return x - (longint'(1) << lw);
    else return x;
  endfunction

  // Reduction unit: lane-wise op of B (high half) with A (low half).
  function automatic logic [63:0] unit_op(input logic [63:0] v, input logic [1:0] s,
                                          input logic [1:0] op);
    int lw; longint m, a, b, r; logic [63:0] o;
    lw = 8 << s; m = (longint'(1) << lw) - 1; o = 64'd0;
    for (int l = 0; l < W / lw; l++) begin
      a = (longint'(v[31:0]) >> (l * lw)) & m;
      b = (longint'(v[63:32]) >> (l * lw)) & m;
      if (op[1]) begin
        a = sext(a, lw); b = sext(b, lw);
        if (op[0]) r = (a > b) ? a : b;
        else       r = (a < b) ? a : b;
        r = r & m;
      end else begin
        r = (a + b) & m;
      end
      o = o | (64'(r) << (l * lw));
    end
    return o;
  endfunction

  always @(posedge clk) if (red_en) red_out <= unit_op(red_vec0, red_sew, red_opSel);

  // Reference: scalar combined with the first vl elements of wbuf.
  function automatic logic [31:0] ref_reduce(input int vl_i, input int sew_i, input int op_i,
                                             input logic [31:0] sc);
    int lw, lanes; longint m, cur, e;
    lw = 8 << sew_i; lanes = W / lw; m = (longint'(1) << lw) - 1;
    cur = longint'(sc) & m;
    if (op_i >= 2) cur = sext(cur, lw);
    for (int k = 0; k < vl_i; k++) begin
      e = (longint'(wbuf[k / lanes]) >> ((k % lanes) * lw)) & m;
      if (op_i < 2) cur = (cur + e) & m;
      else begin
        e = sext(e, lw);
        if (op_i == 2) cur = (e < cur) ? e : cur;
        else           cur = (e > cur) ? e : cur;
      end
    end
    return 32'(cur & m);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pop the scoreboard on every result pulse.
  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_res_valid: got res_data %0h with no pending result", res_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", 64'(res_data), 64'(e.res));
        if (e.lat >= 0) chk("latency", 64'(cyc - last_beat_cyc), 64'(e.lat));
      end
    end
  end

  // Present one word until accepted; called just after a posedge.
  task automatic feed_word(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    in_data = d; in_valid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        last_beat_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got in_ready 0 for 100 cycles expected 1");
    end
  endtask

  task automatic do_red(input int vl_i, input int sew_i, input int op_i, input logic [31:0] sc,
                        input int nw, input logic [31:0] exp_res, input int exp_lat);
    exp_t e; int bad_rdy; bit done;
    e.res = exp_res; e.lat = exp_lat;
    exp_q.push_back(e);
    start = 1'b1; vl = 16'(vl_i); sew = 2'(sew_i); opSel = 2'(op_i); scalar_in = sc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < nw; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if (k == 0) begin
        // start while busy must be ignored
        start = 1'b1; vl = 16'($urandom_range(1, 50)); scalar_in = $urandom;
        opSel = 2'($urandom_range(0, 3));
      end
      feed_word(wbuf[k]);
    end
    start = 1'b0;
    // Extra words offered after the last one must not be taken.
    in_valid = 1'b1; in_data = $urandom;
    bad_rdy = 0; done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (in_ready) bad_rdy++;
      if (!busy) done = 1'b1;
    end
    chk("done_in_time", 64'(done), 64'd1);
    chk("no_extra_ready", 64'(bad_rdy), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; vl = '0; sew = '0; opSel = '0; scalar_in = '0;
    in_data = '0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", 64'({busy, res_valid, in_ready, red_en, red_sew, red_opSel}), 64'd0);
    chk("rst_vec0", red_vec0, 64'd0);
    chk("rst_res", 64'(res_data), 64'd0);
    @(posedge clk); #1;

    // sum sew=8 vl=4, 2 folds -> latency 7
    wbuf[0] = 32'h0403_0201;
    do_red(4, 0, 0, 32'h10, 1, 32'h0000_001A, 7);
    // sum sew=8 vl=6, tail bytes of word 2 nonzero
    wbuf[0] = 32'h0403_0201; wbuf[1] = 32'hFFFF_0605;
    do_red(6, 0, 1, 32'h0, 2, 32'h0000_0015, -1);
    // max sew=16 vl=3
    wbuf[0] = 32'hFFFE_0005; wbuf[1] = 32'h1234_8000;
    do_red(3, 1, 3, 32'h0003, 2, 32'h0000_0005, -1);
    // min sew=32 vl=1, no folds -> latency 3
    wbuf[0] = 32'hFFFF_FFF0;
    do_red(1, 2, 2, 32'h0000_0002, 1, 32'hFFFF_FFF0, 3);
    // vl=0 -> scalar lane 0
    do_red(0, 0, 0, 32'hABCD_EF12, 0, 32'h0000_0012, -1);
    do_red(0, 1, 3, 32'hABCD_EF12, 0, 32'h0000_EF12, -1);

    // Reset while in FOLD_WAIT: beat -> FOLD -> FOLD_WAIT, then rst.
    start = 1'b1; vl = 16'd2; sew = 2'd1; opSel = 2'd3; scalar_in = 32'h7;
    @(posedge clk); #1;
    start = 1'b0;
    feed_word(32'h0005_0003);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", 64'({busy, res_valid, in_ready, red_en, red_sew, red_opSel}), 64'd0);
    chk("midrst_vec0", red_vec0, 64'd0);
    chk("midrst_res", 64'(res_data), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    wbuf[0] = 32'h0005_0003;
    do_red(2, 1, 3, 32'h7, 1, 32'h0000_0007, 5);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      int s, o, v, lanes, nw, lat;
      logic [31:0] sc;
      s = $urandom_range(0, 2);
      o = $urandom_range(0, 3);
      v = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      lanes = 4 >> s;
      nw = (v + lanes - 1) / lanes;
      for (int k = 0; k < nw; k++) wbuf[k] = $urandom;
      sc = $urandom;
      lat = (nw == 1) ? (3 + 2 * (2 - s)) : -1;
      do_red(v, s, o, sc, nw, ref_reduce(v, s, o, sc), lat);
    end

    repeat (5) @(posedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
